text_console: RTL and testbench
===============================

# text_console

Command-driven text-mode console controller that owns write access to the 8 KB text video memory and the hardware cursor registers consumed by the VGA scanout. It accepts one command at a time from the CPU-side bus (put character, set cursor, set attribute, clear screen). It sequences the resulting byte writes into the char/attr cell array, covering line wrap, control characters and full-screen scroll. It sits between the CPU I/O decoder and the text memory write port; the VGA owns the read port.

## Interface
Parameters:
- COLS, 80, text columns
- ROWS, 25, text rows (400 lines / 16-pixel glyphs)
- DEF_ATTR, 8'h07, attribute loaded at reset (bg index [7:4], fg index [3:0])

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, command accepted on valid&&ready
- cmd_op  in  2  0=putchar, 1=set cursor, 2=set attribute, 3=clear screen
- cmd_data  in  16  putchar: [7:0] char; set cursor: [7:0] x, [15:8] y; set attr: [7:0] attr
- cursor_x  out  8  cursor column, to VGA
- cursor_y  out  8  cursor row, to VGA
- mem_address  out  13  text memory byte address (registered)
- mem_wdata  out  8  write data (registered)
- mem_we  out  1  write strobe (registered)
- mem_rdata  in  8  read data; valid the cycle after mem_address is presented

## Operation
- Cell (x,y) layout: char at 2*(x+COLS*y), attr at that address +1. Bytes at 2*COLS*ROWS (0xFA0) and above (palette, font) are never written.
- States: IDLE, WR_CHR, WR_ATR, SCRL_RD, SCRL_WR, FILL_CHR, FILL_ATR.
- putchar 0x0A: x=0, y+1. 0x0D: x=0. 0x08: if x>0 then x-1, else no change. None of these three write memory.
- putchar, other codes: WR_CHR writes char, then WR_ATR writes the current attr and advances x. If x reaches COLS: x=0, y+1.
- When y would reach ROWS: scroll (see Configuration), then y=ROWS-1.
- Scroll: for src = 2*COLS .. 2*COLS*ROWS-1, SCRL_RD presents src and SCRL_WR writes mem_rdata to src-2*COLS. Then FILL writes 0x20/attr over row ROWS-1. Then IDLE.
- set cursor: each coordinate is clamped to COLS-1/ROWS-1. No memory traffic.
- set attr: updates the attribute register only.
- clear: FILL covers all COLS*ROWS cells with 0x20/attr. Then cursor=(0,0).
- Arithmetic: addresses are computed in 13 bits. Byte counters are 13 bits, with no wrap below 0xFA0.

## Timing
- Reset values: cursor_x=0, cursor_y=0, attr=DEF_ATTR, mem_we=0, mem_address=0, mem_wdata=0, state IDLE, cmd_ready=1.
- cmd_ready=1 only in IDLE. A command is accepted on the edge where cmd_valid&&cmd_ready. cmd_data is latched at acceptance and may change afterwards.
- Printable putchar without scroll: mem_we is high for exactly 2 cycles after acceptance (char, then attr). Cursor updates on the attr-write edge. cmd_ready returns 1 in the 3rd cycle after acceptance.
- Control chars, set cursor, set attr: take effect on the accept edge. cmd_ready stays 1; back-to-back acceptance every cycle is legal.
- Scroll: 2 cycles per byte copied (2*COLS*(ROWS-1)*2 = 7680 cycles), then 2*COLS fill cycles. mem_we=0 in every SCRL_RD cycle.
- Clear: 2*COLS*ROWS = 4000 write cycles. Cursor becomes (0,0) on the last write edge.
- Wrap and scroll in the same putchar (char written at (COLS-1,ROWS-1)): the char/attr writes complete first, then the scroll, then x=0, y=ROWS-1.
- cmd_valid while busy: ignored, not queued.
- RESET mid-operation: immediate abort to reset values. Partially copied or filled memory is left as is, and mem_we drops asynchronously.

## Configuration
- CONSOLE_SCROLL_EN defined: scroll hardware (SCRL_RD/SCRL_WR/row fill) is built as above.
- Undefined: no scroll states. When y would reach ROWS, y wraps to 0 with no memory traffic, and old text is overwritten in place.

## Test plan
- Reset, then putchar 'A' (0x41) with attr 0x1E set first -> writes 0x41@0x000 and 0x1E@0x001 on consecutive cycles; cursor (1,0); cmd_ready back on cycle 3.
- set cursor (200,40) -> cursor (79,24); then putchar 'Z' -> 'Z'@0xF9E, attr@0xF9F, then scroll; afterwards cursor (0,24), old row 1 content now at 0x000, and row 24 is 0x20/attr. Without CONSOLE_SCROLL_EN -> cursor (0,0), no further writes.
- putchar 0x08 at x=0, 0x0D, 0x0A -> no mem_we pulses; cursor (0,y+1); cmd_ready never deasserts.
- clear with attr 0x07 -> exactly 4000 mem_we pulses covering 0x000..0xF9F; no write at or above 0xFA0; cursor (0,0).
- Assert RESET during a scroll at cycle 1000 -> mem_we=0 immediately, cursor (0,0), cmd_ready=1 on first clock after release.

Source files
------------

// File: rtl/text_console_if.sv
// Bundles the command port, the VGA cursor outputs and the text memory write port.
// The master side is the CPU/memory environment; the slave side is text_console.
interface text_console_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [7:0]  cursor_x;
    logic [7:0]  cursor_y;
    logic [12:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_data, mem_rdata,
        input  cmd_ready, cursor_x, cursor_y, mem_address, mem_wdata, mem_we
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, mem_rdata,
        output cmd_ready, cursor_x, cursor_y, mem_address, mem_wdata, mem_we
    );
endinterface

// File: rtl/text_console.sv
// Text-mode console controller: turns CPU commands into char/attr writes and cursor moves.
// Define CONSOLE_SCROLL_EN to build the full-screen scroll engine; otherwise the cursor wraps to row 0.
module text_console #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 25,
    parameter logic [7:0] DEF_ATTR = 8'h07
) (
    input  logic           CLOCK,
    input  logic           RESET,
    text_console_if.slave  bus
);
    localparam logic [7:0]  X_MAX     = 8'(COLS - 1);
    localparam logic [7:0]  Y_MAX     = 8'(ROWS - 1);
    localparam logic [12:0] LAST_ADDR = 13'(2 * COLS * ROWS - 1);
`ifdef CONSOLE_SCROLL_EN
    localparam logic [12:0] ROW_BYTES = 13'(2 * COLS);
    localparam logic [12:0] LAST_DST  = 13'(2 * COLS * (ROWS - 1) - 1);
    localparam logic [12:0] FILL_BASE = 13'(2 * COLS * (ROWS - 1));
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_CHR,
        WR_ATR,
`ifdef CONSOLE_SCROLL_EN
        SCRL_RD,
        SCRL_WR,
`endif
        FILL_CHR,
        FILL_ATR
    } state_e;

    state_e      state_q;
    logic [7:0]  x_q, y_q, attr_q;
    logic [12:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic [12:0] cell_addr;
    logic [7:0]  ch;
`ifdef CONSOLE_SCROLL_EN
    logic [12:0] rd_q;
    logic        scroll_fill_q;
`else
    wire         unused_rdata = ^bus.mem_rdata;
`endif

    assign ch        = bus.cmd_data[7:0];
    assign cell_addr = (13'(x_q) + 13'(y_q) * 13'(COLS)) << 1;

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.cursor_x    = x_q;
    assign bus.cursor_y    = y_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_we      = we_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            attr_q  <= DEF_ATTR;
            addr_q  <= 13'd0;
            wdata_q <= 8'd0;
            we_q    <= 1'b0;
`ifdef CONSOLE_SCROLL_EN
            rd_q          <= 13'd0;
            scroll_fill_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    we_q <= 1'b0;
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            2'd0: begin
                                if (ch == 8'h0A) begin
                                    if (y_q == Y_MAX) begin
`ifdef CONSOLE_SCROLL_EN
                                        state_q <= SCRL_RD;
                                        addr_q  <= ROW_BYTES;
                                        rd_q    <= ROW_BYTES;
`else
                                        x_q <= 8'd0;
                                        y_q <= 8'd0;
`endif
                                    end else begin
                                        x_q <= 8'd0;
                                        y_q <= y_q + 8'd1;
                                    end
                                end else if (ch == 8'h0D) begin
                                    x_q <= 8'd0;
                                end else if (ch == 8'h08) begin
                                    if (x_q != 8'd0) x_q <= x_q - 8'd1;
                                end else begin
                                    addr_q  <= cell_addr;
                                    wdata_q <= ch;
                                    we_q    <= 1'b1;
                                    state_q <= WR_CHR;
                                end
                            end
                            2'd1: begin
                                x_q <= (bus.cmd_data[7:0] > X_MAX) ? X_MAX : bus.cmd_data[7:0];
                                y_q <= (bus.cmd_data[15:8] > Y_MAX) ? Y_MAX : bus.cmd_data[15:8];
                            end
                            2'd2: attr_q <= bus.cmd_data[7:0];
                            default: begin
                                addr_q  <= 13'd0;
                                wdata_q <= 8'h20;
                                we_q    <= 1'b1;
                                state_q <= FILL_CHR;
`ifdef CONSOLE_SCROLL_EN
                                scroll_fill_q <= 1'b0;
`endif
                            end
                        endcase
                    end
                end
                WR_CHR: begin
                    addr_q  <= addr_q + 13'd1;
                    wdata_q <= attr_q;
                    state_q <= WR_ATR;
                end
                WR_ATR: begin
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                    if (x_q == X_MAX) begin
                        if (y_q == Y_MAX) begin
`ifdef CONSOLE_SCROLL_EN
                            state_q <= SCRL_RD;
                            addr_q  <= ROW_BYTES;
                            rd_q    <= ROW_BYTES;
`else
                            x_q <= 8'd0;
                            y_q <= 8'd0;
`endif
                        end else begin
                            x_q <= 8'd0;
                            y_q <= y_q + 8'd1;
                        end
                    end else begin
                        x_q <= x_q + 8'd1;
                    end
                end
`ifdef CONSOLE_SCROLL_EN
                // Copy is pipelined R0 R1 W0 R2 W1 ... W(n-1): each write uses data
                // captured into wdata_q while the following read was on the bus.
                SCRL_RD: begin
                    if (rd_q == ROW_BYTES) begin
                        addr_q <= rd_q + 13'd1;
                        rd_q   <= rd_q + 13'd1;
                    end else begin
                        addr_q  <= rd_q - ROW_BYTES - 13'd1;
                        we_q    <= 1'b1;
                        state_q <= SCRL_WR;
                        if (rd_q == ROW_BYTES + 13'd1) wdata_q <= bus.mem_rdata;
                    end
                end
                SCRL_WR: begin
                    wdata_q <= bus.mem_rdata;
                    if (addr_q == LAST_DST) begin
                        addr_q        <= FILL_BASE;
                        wdata_q       <= 8'h20;
                        scroll_fill_q <= 1'b1;
                        state_q       <= FILL_CHR;
                    end else if (rd_q == LAST_ADDR) begin
                        addr_q <= addr_q + 13'd1;
                    end else begin
                        addr_q  <= rd_q + 13'd1;
                        rd_q    <= rd_q + 13'd1;
                        we_q    <= 1'b0;
                        state_q <= SCRL_RD;
                    end
                end
`endif
                FILL_CHR: begin
                    addr_q  <= addr_q + 13'd1;
                    wdata_q <= attr_q;
                    state_q <= FILL_ATR;
                end
                FILL_ATR: begin
                    if (addr_q == LAST_ADDR) begin
                        we_q    <= 1'b0;
                        state_q <= IDLE;
                        x_q     <= 8'd0;
`ifdef CONSOLE_SCROLL_EN
                        y_q     <= scroll_fill_q ? Y_MAX : 8'd0;
`else
                        y_q     <= 8'd0;
`endif
                    end else begin
                        addr_q  <= addr_q + 13'd1;
                        wdata_q <= 8'h20;
                        state_q <= FILL_CHR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: expected memory writes are queued at stimulus time
// and a negedge monitor pops and compares each mem_we cycle against them.
module tb_text_console;
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLOCK = ~CLOCK;

    text_console_if bus ();

    text_console #(.COLS(80), .ROWS(25), .DEF_ATTR(8'h07)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] mem     [0:8191];
    logic [7:0] ref_mem [0:4095];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_writes = 0;

    // Memory with one-cycle registered read
    always @(posedge CLOCK) begin
        if (bus.mem_we) mem[bus.mem_address] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_address];
    end

    always @(negedge CLOCK) begin
        if (!RESET && bus.mem_we) begin
            wr_t e;
            n_checks++;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%03h data=%02h, required no write",
                         bus.mem_address, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_address !== e.addr || bus.mem_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write_compare: got addr=%03h data=%02h, required addr=%03h data=%02h",
                             bus.mem_address, bus.mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [12:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        ref_mem[int'(a)] = d;
    endtask

    task automatic push_fill(input int first, input logic [7:0] attr);
        for (int a = first; a < 4000; a += 2) begin
            push(13'(a), 8'h20);
            push(13'(a + 1), attr);
        end
    endtask

    // Issue one command; returns 1 time unit after the accept edge
    task automatic send(input logic [1:0] op, input logic [15:0] data);
        @(negedge CLOCK);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        $display("cmd op=%0d data=%04h cursor=(%0d,%0d)", op, data, bus.cursor_x, bus.cursor_y);
        @(posedge CLOCK);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 16'hDEAD;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        check(name, {15'd0, bus.cmd_ready}, 16'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 16'h0000;

        repeat (3) @(posedge CLOCK);
        #1;
        check("reset_cursor_x", {8'd0, bus.cursor_x}, 16'd0);
        check("reset_cursor_y", {8'd0, bus.cursor_y}, 16'd0);
        check("reset_ready", {15'd0, bus.cmd_ready}, 16'd1);
        check("reset_we", {15'd0, bus.mem_we}, 16'd0);
        check("reset_addr", {3'd0, bus.mem_address}, 16'd0);
        check("reset_wdata", {8'd0, bus.mem_wdata}, 16'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // attr 0x1E then 'A': two writes, cursor moves on the attr edge, ready in cycle 3
        send(2'd2, 16'h001E);
        push(13'h000, 8'h41);
        push(13'h001, 8'h1E);
        send(2'd0, 16'h0041);
        check("putc_ready_c1", {15'd0, bus.cmd_ready}, 16'd0);
        @(posedge CLOCK); #1;
        check("putc_ready_c2", {15'd0, bus.cmd_ready}, 16'd0);
        check("putc_x_c2", {8'd0, bus.cursor_x}, 16'd0);
        @(posedge CLOCK); #1;
        check("putc_ready_c3", {15'd0, bus.cmd_ready}, 16'd1);
        check("putc_x_c3", {8'd0, bus.cursor_x}, 16'd1);
        check("putc_y_c3", {8'd0, bus.cursor_y}, 16'd0);
        check("putc_writes", 16'(n_writes), 16'd2);

        // Control characters back to back: no writes, ready never drops
        send(2'd1, 16'h0300);
        check("ctl_ready_setcur", {15'd0, bus.cmd_ready}, 16'd1);
        send(2'd0, 16'h0008);
        check("bs_at_x0", {bus.cursor_y, bus.cursor_x}, 16'h0300);
        check("ctl_ready_bs", {15'd0, bus.cmd_ready}, 16'd1);
        send(2'd0, 16'h000D);
        check("cr_cursor", {bus.cursor_y, bus.cursor_x}, 16'h0300);
        send(2'd0, 16'h000A);
        check("lf_cursor", {bus.cursor_y, bus.cursor_x}, 16'h0400);
        check("ctl_ready_lf", {15'd0, bus.cmd_ready}, 16'd1);
        check("ctl_no_writes", 16'(n_writes), 16'd2);

        // Clear with attr 0x07: 4000 writes over 0x000..0xF9F, cursor to origin
        send(2'd2, 16'h0007);
        push_fill(0, 8'h07);
        send(2'd3, 16'h0000);
        check("clear_busy", {15'd0, bus.cmd_ready}, 16'd0);
        wait_idle(5000, "clear_done");
        check("clear_writes", 16'(n_writes), 16'd4002);
        check("clear_cursor", {bus.cursor_y, bus.cursor_x}, 16'h0000);
        check("clear_queue", 16'(exp_q.size()), 16'd0);

        // Mark row 1 so the scroll result is recognisable
        send(2'd1, 16'h0100);
        send(2'd2, 16'h002C);
        push(13'h0A0, 8'h48);
        push(13'h0A1, 8'h2C);
        send(2'd0, 16'h0048);
        wait_idle(10, "row1_h");
        push(13'h0A2, 8'h69);
        push(13'h0A3, 8'h2C);
        send(2'd0, 16'h0069);
        wait_idle(10, "row1_i");

        // Clamped cursor then 'Z' in the bottom-right cell
        send(2'd2, 16'h004F);
        send(2'd1, 16'h28C8);
        check("clamp_cursor", {bus.cursor_y, bus.cursor_x}, {8'd24, 8'd79});
        push(13'hF9E, 8'h5A);
        push(13'hF9F, 8'h4F);
`ifdef CONSOLE_SCROLL_EN
        for (int d = 0; d < 3840; d++) push(13'(d), ref_mem[d + 160]);
        push_fill(3840, 8'h4F);
        send(2'd0, 16'h005A);
        wait_idle(9000, "scroll_done");
        check("scroll_cursor", {bus.cursor_y, bus.cursor_x}, {8'd24, 8'd0});
        check("scroll_row0_char", {8'd0, mem[0]}, 16'h0048);
        check("scroll_row0_attr", {8'd0, mem[1]}, 16'h002C);
        check("scroll_last_attr", {8'd0, mem[13'hF9F]}, 16'h004F);
        check("scroll_queue", 16'(exp_q.size()), 16'd0);

        // LF at bottom row starts a scroll; reset it part way through
        for (int d = 0; d < 3840; d++) push(13'(d), ref_mem[d + 160]);
        push_fill(3840, 8'h4F);
        send(2'd0, 16'h000A);
`else
        send(2'd0, 16'h005A);
        wait_idle(10, "wrap_done");
        repeat (20) @(negedge CLOCK);
        check("wrap_cursor", {bus.cursor_y, bus.cursor_x}, 16'h0000);
        check("wrap_queue", 16'(exp_q.size()), 16'd0);

        // Clear from a non-zero cursor; reset it part way through
        send(2'd1, 16'h0907);
        push_fill(0, 8'h4F);
        send(2'd3, 16'h0000);
`endif
        check("long_op_busy", {15'd0, bus.cmd_ready}, 16'd0);
        repeat (1000) @(posedge CLOCK);
        #3;
        RESET = 1'b1;
        exp_q.delete();
        #1;
        check("abort_we", {15'd0, bus.mem_we}, 16'd0);
        check("abort_cursor", {bus.cursor_y, bus.cursor_x}, 16'h0000);
        @(negedge CLOCK);
        RESET = 1'b0;
        @(posedge CLOCK); #1;
        check("abort_ready", {15'd0, bus.cmd_ready}, 16'd1);

        // Attribute returns to its reset default
        push(13'h000, 8'h42);
        push(13'h001, 8'h07);
        send(2'd0, 16'h0042);
        wait_idle(10, "post_reset_putc");
        check("post_reset_cursor", {bus.cursor_y, bus.cursor_x}, 16'h0001);
        check("final_queue", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
